// File: rtl/tick_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tick_burst_ctrl
//
// Purpose
//   Turns a free-running prescaler tick (1-cycle TICK_IN pulses) into
//   programmable pulse bursts. TICK_IN is divided by (period_reg + 1) and
//   each division boundary produces one registered POUT pulse. A burst runs
//   either for count_reg pulses (one-shot) or until STOP (continuous).
//
// Optional feature
//   TBC_IRQ_EN : when defined, adds a sticky completion interrupt
//                (IRQ output, IRQ_CLR input). Undefined by default.
//
// Ports
//   CLK        in        clock, all logic on rising edge
//   R          in        synchronous reset, active-high, overrides everything
//   TICK_IN    in        1-cycle prescaler tick
//   START      in        start request (level, sampled each cycle)
//   STOP       in        abort request
//   CFG_WE     in        configuration write strobe (accepted only in IDLE)
//   CFG_PERIOD in  [PW]  divider period, POUT every CFG_PERIOD+1 ticks
//   CFG_COUNT  in  [CW]  pulses per one-shot burst
//   CFG_MODE   in        0 = one-shot, 1 = continuous
//   POUT       out       registered 1-cycle output pulse
//   BUSY       out       high while in RUN
//   DONE       out       1-cycle pulse on burst completion
//   CFG_ERR    out       sticky: CFG_WE seen outside IDLE
//   IRQ        out       (TBC_IRQ_EN only) sticky completion interrupt
//   IRQ_CLR    in        (TBC_IRQ_EN only) interrupt clear
//   PULSE_CNT  out [CW]  pulses emitted since last START
// -----------------------------------------------------------------------------
module tick_burst_ctrl #(
    parameter int               PW         = 8,
    parameter int               CW         = 16,
    parameter logic [PW-1:0]    DEF_PERIOD = 8'hFF,
    parameter logic [CW-1:0]    DEF_COUNT  = 16'd1
) (
    input  logic          CLK,
    input  logic          R,
    input  logic          TICK_IN,
    input  logic          START,
    input  logic          STOP,
    input  logic          CFG_WE,
    input  logic [PW-1:0] CFG_PERIOD,
    input  logic [CW-1:0] CFG_COUNT,
    input  logic          CFG_MODE,
    output logic          POUT,
    output logic          BUSY,
    output logic          DONE,
    output logic          CFG_ERR,
`ifdef TBC_IRQ_EN
    output logic          IRQ,
    input  logic          IRQ_CLR,
`endif
    output logic [CW-1:0] PULSE_CNT
);

    localparam logic [PW-1:0] ZERO_P = {PW{1'b0}};
    localparam logic [PW-1:0] ONE_P  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t        state_q,     state_d;
    logic [PW-1:0] div_cnt_q,   div_cnt_d;
    logic [PW-1:0] period_q,    period_d;
    logic [CW-1:0] count_q,     count_d;
    logic          mode_q,      mode_d;
    logic          pout_q,      pout_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;
    logic          cfg_err_q,   cfg_err_d;
    logic [CW-1:0] pulse_cnt_q, pulse_cnt_d;

    // Configuration as seen by a START in the same cycle as CFG_WE
    logic [CW-1:0] eff_count_s;
    logic          eff_mode_s;
    logic [CW-1:0] pulse_cnt_inc_s;

    // Select freshly written config over the stored one for a same-cycle START
    always_comb begin
        eff_count_s = count_q;
        eff_mode_s  = mode_q;
        if (CFG_WE) begin
            eff_count_s = CFG_COUNT;
            eff_mode_s  = CFG_MODE;
        end else begin
            eff_count_s = count_q;
            eff_mode_s  = mode_q;
        end
    end

    assign pulse_cnt_inc_s = pulse_cnt_q + ONE_C;

    // Next-state and next-output logic for the burst sequencer
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        period_d    = period_q;
        count_d     = count_q;
        mode_d      = mode_q;
        pout_d      = 1'b0;
        done_d      = 1'b0;
        cfg_err_d   = cfg_err_q;
        pulse_cnt_d = pulse_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (CFG_WE) begin
                    period_d  = CFG_PERIOD;
                    count_d   = CFG_COUNT;
                    mode_d    = CFG_MODE;
                    cfg_err_d = 1'b0;
                end else begin
                    cfg_err_d = cfg_err_q;
                end

                if (START && !STOP) begin
                    div_cnt_d   = ZERO_P;
                    pulse_cnt_d = ZERO_C;
                    // An empty one-shot burst completes without any pulse
                    if (!eff_mode_s && (eff_count_s == ZERO_C)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (CFG_WE) begin
                    cfg_err_d = 1'b1;
                end else begin
                    cfg_err_d = cfg_err_q;
                end

                // STOP takes priority over a pulse due in the same cycle
                if (STOP) begin
                    state_d = ST_IDLE;
                end else if (TICK_IN) begin
                    if (div_cnt_q == period_q) begin
                        div_cnt_d   = ZERO_P;
                        pout_d      = 1'b1;
                        pulse_cnt_d = pulse_cnt_inc_s;
                        if (!mode_q && (pulse_cnt_inc_s == count_q)) begin
                            state_d = ST_FIN;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + ONE_P;
                    end
                end else begin
                    div_cnt_d = div_cnt_q;
                end
            end

            ST_FIN: begin
                // DONE is registered out of FIN, so it is seen the cycle after
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (CFG_WE) begin
                    cfg_err_d = 1'b1;
                end else begin
                    cfg_err_d = cfg_err_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge CLK) begin
        if (R) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= ZERO_P;
            period_q    <= DEF_PERIOD;
            count_q     <= DEF_COUNT;
            mode_q      <= 1'b0;
            pout_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            pulse_cnt_q <= ZERO_C;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            period_q    <= period_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            pout_q      <= pout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign POUT      = pout_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign CFG_ERR   = cfg_err_q;
    assign PULSE_CNT = pulse_cnt_q;

`ifdef TBC_IRQ_EN
    logic irq_q, irq_d;

    // Interrupt sets on a visible DONE; a same-cycle clear loses to the set
    always_comb begin
        irq_d = irq_q;
        if (done_q) begin
            irq_d = 1'b1;
        end else if (IRQ_CLR) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Interrupt flag register
    always_ff @(posedge CLK) begin
        if (R) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign IRQ = irq_q;
`endif

endmodule

// File: tb/tb_tick_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tick_burst_ctrl : directed, self-checking bench for tick_burst_ctrl.
// Expected POUT pulses (cycle + PULSE_CNT) and DONE cycles are queued when the
// stimulus is applied; a negedge monitor pops and compares them as they appear.
// -----------------------------------------------------------------------------
module tb_tick_burst_ctrl;

    logic        CLK;
    logic        R;
    logic        TICK_IN;
    logic        START;
    logic        STOP;
    logic        CFG_WE;
    logic [7:0]  CFG_PERIOD;
    logic [15:0] CFG_COUNT;
    logic        CFG_MODE;
    logic        POUT;
    logic        BUSY;
    logic        DONE;
    logic        CFG_ERR;
    logic [15:0] PULSE_CNT;
`ifdef TBC_IRQ_EN
    logic        IRQ;
    logic        IRQ_CLR;
`endif

    tick_burst_ctrl dut (
        .CLK        (CLK),
        .R          (R),
        .TICK_IN    (TICK_IN),
        .START      (START),
        .STOP       (STOP),
        .CFG_WE     (CFG_WE),
        .CFG_PERIOD (CFG_PERIOD),
        .CFG_COUNT  (CFG_COUNT),
        .CFG_MODE   (CFG_MODE),
        .POUT       (POUT),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .CFG_ERR    (CFG_ERR),
`ifdef TBC_IRQ_EN
        .IRQ        (IRQ),
        .IRQ_CLR    (IRQ_CLR),
`endif
        .PULSE_CNT  (PULSE_CNT)
    );

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
    } pexp_t;

    pexp_t pq[$];
    int    dq[$];
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;
    int    s;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count rising edges; after edge k the negedge sees cyc == k
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Scoreboard monitor: every POUT/DONE must match the head of its queue
    always @(negedge CLK) begin
        pexp_t e;
        int    d;
        if (POUT === 1'b1) begin
            if (pq.size() > 0) e = pq.pop_front();
            else begin
                e.cyc = -1;
                e.cnt = 16'hFFFF;
            end
            checks++;
            assert (cyc === e.cyc) else begin
                errors++;
                $error("FAIL pout_cycle observed=%0d expected=%0d", cyc, e.cyc);
            end
            checks++;
            assert (PULSE_CNT === e.cnt) else begin
                errors++;
                $error("FAIL pout_cnt observed=%0d expected=%0d", PULSE_CNT, e.cnt);
            end
        end
        if (DONE === 1'b1) begin
            d = (dq.size() > 0) ? dq.pop_front() : -1;
            checks++;
            assert (cyc === d) else begin
                errors++;
                $error("FAIL done_cycle observed=%0d expected=%0d", cyc, d);
            end
        end
    end

    initial begin
        R = 1'b1; TICK_IN = 1'b0; START = 1'b0; STOP = 1'b0;
        CFG_WE = 1'b0; CFG_PERIOD = 8'd0; CFG_COUNT = 16'd0; CFG_MODE = 1'b0;
`ifdef TBC_IRQ_EN
        IRQ_CLR = 1'b0;
`endif
        step(); step();
        R = 1'b0;
        check("rst_pout",  {31'd0, POUT},    32'd0);
        check("rst_busy",  {31'd0, BUSY},    32'd0);
        check("rst_done",  {31'd0, DONE},    32'd0);
        check("rst_err",   {31'd0, CFG_ERR}, 32'd0);
        check("rst_pcnt",  {16'd0, PULSE_CNT}, 32'd0);

        // 1: defaults (period 255, count 1, one-shot), tick every cycle
        START = 1'b1; TICK_IN = 1'b1;
        s = cyc + 1;
        pq.push_back('{s + 256, 16'd1});
        dq.push_back(s + 257);
        step();
        START = 1'b0;
        check("t1_busy", {31'd0, BUSY}, 32'd1);
        for (int i = 0; i < 270; i++) step();
        TICK_IN = 1'b0;
        check("t1_pcnt", {16'd0, PULSE_CNT}, 32'd1);
        check("t1_busy_after", {31'd0, BUSY}, 32'd0);
        check("t1_pq_empty", pq.size(), 32'd0);
        check("t1_dq_empty", dq.size(), 32'd0);

        // 2: period 2, count 3, one-shot, tick every 4th cycle
        CFG_WE = 1'b1; CFG_PERIOD = 8'd2; CFG_COUNT = 16'd3; CFG_MODE = 1'b0;
        step();
        CFG_WE = 1'b0; START = 1'b1;
        s = cyc + 1;
        pq.push_back('{s + 12, 16'd1});
        pq.push_back('{s + 24, 16'd2});
        pq.push_back('{s + 36, 16'd3});
        dq.push_back(s + 37);
        step();
        START = 1'b0;
        for (int i = 0; i < 60; i++) begin
            TICK_IN = ((i % 4) == 3);
            step();
        end
        TICK_IN = 1'b0;
        check("t2_pcnt", {16'd0, PULSE_CNT}, 32'd3);
        check("t2_busy", {31'd0, BUSY}, 32'd0);
        check("t2_pq_empty", pq.size(), 32'd0);
        check("t2_dq_empty", dq.size(), 32'd0);
`ifdef TBC_IRQ_EN
        check("t2_irq_set", {31'd0, IRQ}, 32'd1);
        IRQ_CLR = 1'b1;
        step();
        IRQ_CLR = 1'b0;
        check("t2_irq_clr", {31'd0, IRQ}, 32'd0);
`endif

        // 3: continuous, period 0, config written with START; STOP on a due tick
        CFG_WE = 1'b1; CFG_PERIOD = 8'd0; CFG_COUNT = 16'd5; CFG_MODE = 1'b1;
        START = 1'b1;
        s = cyc + 1;
        for (int j = 1; j <= 10; j++) pq.push_back('{s + j, 16'(j)});
        step();
        CFG_WE = 1'b0; START = 1'b0;
        check("t3_err_clear", {31'd0, CFG_ERR}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            TICK_IN = 1'b1;
            step();
        end
        STOP = 1'b1; TICK_IN = 1'b1;
        step();
        STOP = 1'b0; TICK_IN = 1'b0;
        check("t3_pcnt", {16'd0, PULSE_CNT}, 32'd10);
        check("t3_busy", {31'd0, BUSY}, 32'd0);
        step();
        check("t3_pq_empty", pq.size(), 32'd0);

        // 4: CFG_WE during RUN flags an error and leaves period unchanged
        CFG_WE = 1'b1; CFG_PERIOD = 8'd3; CFG_MODE = 1'b1;
        step();
        CFG_WE = 1'b0; START = 1'b1;
        s = cyc + 1;
        step();
        START = 1'b0;
        CFG_WE = 1'b1; CFG_PERIOD = 8'd0;
        step();
        CFG_WE = 1'b0;
        check("t4_err_set", {31'd0, CFG_ERR}, 32'd1);
        pq.push_back('{s + 5, 16'd1});
        pq.push_back('{s + 9, 16'd2});
        for (int i = 0; i < 8; i++) begin
            TICK_IN = 1'b1;
            step();
        end
        TICK_IN = 1'b0; STOP = 1'b1;
        step();
        STOP = 1'b0;
        check("t4_pq_empty", pq.size(), 32'd0);
        check("t4_err_sticky", {31'd0, CFG_ERR}, 32'd1);
        CFG_WE = 1'b1; CFG_PERIOD = 8'd1; CFG_COUNT = 16'd10; CFG_MODE = 1'b0;
        step();
        CFG_WE = 1'b0;
        check("t4_err_cleared", {31'd0, CFG_ERR}, 32'd0);

        // 5: reset mid-burst (period 1, count 10, one-shot)
        START = 1'b1;
        s = cyc + 1;
        pq.push_back('{s + 2, 16'd1});
        step();
        START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            TICK_IN = 1'b1;
            step();
        end
        R = 1'b1; TICK_IN = 1'b1;
        step();
        R = 1'b0; TICK_IN = 1'b0;
        check("t5_rst_pout", {31'd0, POUT}, 32'd0);
        check("t5_rst_busy", {31'd0, BUSY}, 32'd0);
        check("t5_rst_done", {31'd0, DONE}, 32'd0);
        check("t5_rst_pcnt", {16'd0, PULSE_CNT}, 32'd0);
`ifdef TBC_IRQ_EN
        check("t5_rst_irq", {31'd0, IRQ}, 32'd0);
`endif
        check("t5_pq_empty", pq.size(), 32'd0);

        // period back to 255 after reset: single pulse after 256 ticks
        START = 1'b1; TICK_IN = 1'b1;
        s = cyc + 1;
        pq.push_back('{s + 256, 16'd1});
        dq.push_back(s + 257);
        step();
        START = 1'b0;
        for (int i = 0; i < 260; i++) step();
        TICK_IN = 1'b0;
        check("t5_def_pq_empty", pq.size(), 32'd0);
        check("t5_def_dq_empty", dq.size(), 32'd0);

        // one-shot with count 0: DONE without any POUT
        CFG_WE = 1'b1; CFG_PERIOD = 8'd5; CFG_COUNT = 16'd0; CFG_MODE = 1'b0;
        START = 1'b1; TICK_IN = 1'b1;
        s = cyc + 1;
        dq.push_back(s + 1);
        step();
        CFG_WE = 1'b0; START = 1'b0;
        check("t5_zero_busy", {31'd0, BUSY}, 32'd0);
        step();
`ifdef TBC_IRQ_EN
        IRQ_CLR = 1'b1;
`endif
        step();
`ifdef TBC_IRQ_EN
        IRQ_CLR = 1'b0;
        check("t6_irq_set_wins", {31'd0, IRQ}, 32'd1);
`endif
        TICK_IN = 1'b0;
        check("t5_zero_pcnt", {16'd0, PULSE_CNT}, 32'd0);
        check("t5_zero_dq_empty", dq.size(), 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
